fht_but_pipe: RTL and testbench
===============================

Name: fht_but_pipe

Overview:
Parametrised, pipelined radix-2 FHT butterfly that computes Y0 = X0 + (X1·cos + X2·sin) and Y1 = X0 − (X1·cos + X2·sin) in fixed point. It succeeds the fixed-width butterfly with the following additions:
- valid tracking and a pipeline stall input;
- a per-sample bypass mode for the twiddle-free first stage;
- per-sample selectable halving or saturating output;
- a sticky overflow flag.
It sits between the FHT data RAM read mux and the write-back path, driven by the stage/address controller.

Parameters:
D_BIT, 17, data word width (signed two's complement)
W_BIT, 12, twiddle width, signed Q1.(W_BIT-1): +1.0 is not representable, and -1.0 = -2^(W_BIT-1)

Ports:
iCLK  in  1  clock, rising edge
iRESET  in  1  asynchronous active-low reset
iVALID  in  1  input sample valid
iSTALL  in  1  hold whole pipeline (no capture, no advance)
iBYPASS  in  1  1: multiplier result replaced by iX_1 (stage 0)
iSCALE  in  1  1: outputs halved with rounding; 0: outputs saturated to D_BIT
iOVF_CLR  in  1  clear sticky overflow flag
iX_0  in  D_BIT  signed data
iX_1  in  D_BIT  signed data
iX_2  in  D_BIT  signed data
iSIN  in  W_BIT  signed twiddle
iCOS  in  W_BIT  signed twiddle
oY_0  out  D_BIT  sum output
oY_1  out  D_BIT  difference output
oVALID  out  1  oY_0/oY_1 valid
oOVF  out  1  sticky saturation flag

Behaviour:
- Reset (async, iRESET=0): all pipeline registers, oY_0, oY_1, oVALID and oOVF go to 0 immediately. A reset mid-operation discards in-flight samples, and no oVALID pulse follows the reset release.
- Pipeline: 2 stages, fixed latency 2 un-stalled clocks from iVALID capture to oVALID.
- While iSTALL=1, every register including oVALID, the outputs and oOVF holds its value. The inputs are ignored. iOVF_CLR is still honoured.
- Stage 1, on a clock edge with iSTALL=0:
  - captures v1 <= iVALID, the mode bits bypass1/scale1, and x0_d <= iX_0.
  - if iBYPASS=1: m <= iX_1.
  - else: P = iX_1·iCOS + iX_2·iSIN + 2^(W_BIT-2), computed at full width D_BIT+W_BIT+1. The rounded quotient q = P >>> (W_BIT-1) is saturated to the D_BIT range, and m <= sat(q).
  - Stage-1 saturation raises ovf1 = 1, carried with the sample.
  - Data registers load regardless of iVALID; only the valid bits qualify them.
- Stage 2, on a clock edge with iSTALL=0:
  - computes S = x0_d + m and D = x0_d − m at D_BIT+1 bits.
  - if scale1=1: oY_0 <= (S+1)>>>1 and oY_1 <= (D+1)>>>1. These never overflow.
  - if scale1=0: oY_0 <= sat(S) and oY_1 <= sat(D), clamped to [−2^(D_BIT-1), 2^(D_BIT-1)−1].
  - oVALID <= v1.
- oOVF:
  - set on the edge where a valid sample (v1=1) leaving stage 2 saturated at stage 1 or stage 2.
  - cleared by iOVF_CLR=1 on a clock edge.
  - if set and clear occur in the same cycle, set wins.
  - saturation on non-valid slots never sets oOVF.
- Mode bits (iBYPASS, iSCALE) are sampled per sample with the data, so modes may change every cycle without corrupting in-flight samples.
- Throughput: one sample per un-stalled clock. Back-to-back iVALID produces back-to-back oVALID.

Test Plan:
- Bypass, iSCALE=1, X0=100, X1=50 -> two cycles later oY_0=75, oY_1=25, oVALID=1 for exactly one cycle.
- iBYPASS=0, iSCALE=0, X0=0, X1=1000, X2=0, COS=1024, SIN=0 -> oY_0=500, oY_1=−500, oOVF=0.
- Saturation: bypass, iSCALE=0, X0=60000, X1=10000 -> oY_0=65535, oY_1=50000, oOVF=1 and held. Next cycle iOVF_CLR=1 -> oOVF=0. X1=−65536, COS=−2048, SIN=0, X0=0, iSCALE=0 -> m saturates to 65535, oY_0=65535, oY_1=−65535, oOVF=1.
- Stream of 4 back-to-back samples with iSTALL=1 for 3 cycles after the 2nd -> outputs/oVALID frozen during the stall, all 4 results emerge in order, none lost or duplicated. Total clocks = 4+2+3.
- Alternate iBYPASS/iSCALE every sample with 8 random samples -> each output matches the golden model for its own mode.
- Assert iRESET low while 2 samples are in flight -> outputs immediately 0 and oVALID=0. After release with iVALID=0, oVALID stays 0.

Source files
------------

// File: rtl/fht_but_pipe_if.sv
// Sample/twiddle/mode bus into the FHT butterfly and the result bus out of it.
// master = stage/address controller side, slave = butterfly.
interface fht_but_pipe_if #(
  parameter int D_BIT = 17,
  parameter int W_BIT = 12
);
  logic                    iVALID;
  logic                    iSTALL;
  logic                    iBYPASS;
  logic                    iSCALE;
  logic                    iOVF_CLR;
  logic signed [D_BIT-1:0] iX_0;
  logic signed [D_BIT-1:0] iX_1;
  logic signed [D_BIT-1:0] iX_2;
  logic signed [W_BIT-1:0] iSIN;
  logic signed [W_BIT-1:0] iCOS;
  logic signed [D_BIT-1:0] oY_0;
  logic signed [D_BIT-1:0] oY_1;
  logic                    oVALID;
  logic                    oOVF;

  modport master (
    output iVALID, iSTALL, iBYPASS, iSCALE, iOVF_CLR, iX_0, iX_1, iX_2, iSIN, iCOS,
    input  oY_0, oY_1, oVALID, oOVF
  );
  modport slave (
    input  iVALID, iSTALL, iBYPASS, iSCALE, iOVF_CLR, iX_0, iX_1, iX_2, iSIN, iCOS,
    output oY_0, oY_1, oVALID, oOVF
  );
endinterface

// File: rtl/fht_but_pipe.sv
// Two-stage radix-2 FHT butterfly: Y0/Y1 = X0 +/- (X1*cos + X2*sin), with stall,
// per-sample twiddle bypass, per-sample halve-or-saturate and a sticky overflow flag.
module fht_but_pipe #(
  parameter int D_BIT = 17,
  parameter int W_BIT = 12
) (
  input logic           iCLK,
  input logic           iRESET,
  fht_but_pipe_if.slave bus
);
  localparam int PW = D_BIT + W_BIT + 1;
  localparam int SW = D_BIT + 1;
  localparam logic signed [PW-1:0]    P_RND = PW'(1 << (W_BIT-2));
  localparam logic signed [PW-1:0]    P_MAX = PW'((1 << (D_BIT-1)) - 1);
  localparam logic signed [PW-1:0]    P_MIN = PW'(-(1 << (D_BIT-1)));
  localparam logic signed [SW-1:0]    S_ONE = SW'(1);
  localparam logic signed [D_BIT-1:0] D_MAX = {1'b0, {(D_BIT-1){1'b1}}};
  localparam logic signed [D_BIT-1:0] D_MIN = {1'b1, {(D_BIT-1){1'b0}}};

  logic signed [PW-1:0]    x1_e, x2_e, cos_e, sin_e, p, q;
  logic signed [SW-1:0]    s_sum, s_dif, s_sum_r, s_dif_r;
  logic signed [D_BIT-1:0] x0_d, x0_q, m_d, m_q, y0_d, y0_q, y1_d, y1_q;
  logic [2:1]              vld_pipe_d, vld_pipe_q;
  logic                    scale1_d, scale1_q, ovf1_d, ovf1_q, ovf_d, ovf_q;
  logic                    sat1, sat_s, sat_d, ovf_set;

  // Stage 1: rotate X1/X2 by the twiddle, round half-up, clamp to D_BIT
  always_comb begin
    x1_e  = PW'(bus.iX_1);
    x2_e  = PW'(bus.iX_2);
    cos_e = PW'(bus.iCOS);
    sin_e = PW'(bus.iSIN);
    p     = x1_e * cos_e + x2_e * sin_e + P_RND;
    q     = p >>> (W_BIT-1);
    sat1  = (q > P_MAX) || (q < P_MIN);

    vld_pipe_d[1] = vld_pipe_q[1];
    x0_d          = x0_q;
    m_d           = m_q;
    scale1_d      = scale1_q;
    ovf1_d        = ovf1_q;
    if (!bus.iSTALL) begin
      vld_pipe_d[1] = bus.iVALID;
      x0_d          = bus.iX_0;
      scale1_d      = bus.iSCALE;
      if (bus.iBYPASS) begin
        m_d    = bus.iX_1;
        ovf1_d = 1'b0;
      end else begin
        m_d    = sat1 ? (q[PW-1] ? D_MIN : D_MAX) : q[D_BIT-1:0];
        ovf1_d = sat1;
      end
    end
  end

  // Stage 2: one guard bit is enough for both the sum and the halving round
  always_comb begin
    s_sum   = SW'(x0_q) + SW'(m_q);
    s_dif   = SW'(x0_q) - SW'(m_q);
    s_sum_r = (s_sum + S_ONE) >>> 1;
    s_dif_r = (s_dif + S_ONE) >>> 1;
    sat_s   = s_sum[SW-1] != s_sum[SW-2];
    sat_d   = s_dif[SW-1] != s_dif[SW-2];

    vld_pipe_d[2] = vld_pipe_q[2];
    y0_d          = y0_q;
    y1_d          = y1_q;
    ovf_set       = 1'b0;
    if (!bus.iSTALL) begin
      vld_pipe_d[2] = vld_pipe_q[1];
      ovf_set       = vld_pipe_q[1] && (ovf1_q || (!scale1_q && (sat_s || sat_d)));
      if (scale1_q) begin
        y0_d = s_sum_r[D_BIT-1:0];
        y1_d = s_dif_r[D_BIT-1:0];
      end else begin
        y0_d = sat_s ? (s_sum[SW-1] ? D_MIN : D_MAX) : s_sum[D_BIT-1:0];
        y1_d = sat_d ? (s_dif[SW-1] ? D_MIN : D_MAX) : s_dif[D_BIT-1:0];
      end
    end
    // clear is honoured even while stalled; a same-cycle set wins
    ovf_d = ovf_set ? 1'b1 : (bus.iOVF_CLR ? 1'b0 : ovf_q);
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      vld_pipe_q <= '0;
      x0_q       <= '0;
      m_q        <= '0;
      scale1_q   <= 1'b0;
      ovf1_q     <= 1'b0;
      y0_q       <= '0;
      y1_q       <= '0;
      ovf_q      <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      x0_q       <= x0_d;
      m_q        <= m_d;
      scale1_q   <= scale1_d;
      ovf1_q     <= ovf1_d;
      y0_q       <= y0_d;
      y1_q       <= y1_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.oY_0   = y0_q;
  assign bus.oY_1   = y1_q;
  assign bus.oVALID = vld_pipe_q[2];
  assign bus.oOVF   = ovf_q;
endmodule

// File: tb/tb_fht_but_pipe.sv
// Self-checking bench for fht_but_pipe: directed cases plus randomized streams
// checked against an arithmetic reference model of the butterfly.
module tb_fht_but_pipe;
  localparam int D_BIT = 17;
  localparam int W_BIT = 12;

  logic iCLK   = 1'b0;
  logic iRESET = 1'b1;
  always #5 iCLK = ~iCLK;

  fht_but_pipe_if #(.D_BIT(D_BIT), .W_BIT(W_BIT)) bus ();
  fht_but_pipe #(.D_BIT(D_BIT), .W_BIT(W_BIT)) dut (.iCLK(iCLK), .iRESET(iRESET), .bus(bus));

  typedef struct { longint x0, x1, x2, c, s; bit byp, scl; } smp_t;
  typedef struct { longint y0, y1; bit ovf; } res_t;

  int vectors = 0;
  int errors  = 0;

  // reference state: sample waiting in the pipe, sample at the output, sticky flag
  bit   m_stg_vld, m_out_vld, m_ovf;
  res_t m_stg, m_out;
  smp_t z = '{default: 0};

  function automatic longint fdiv(longint a, longint b);
    longint r = a / b;
    if ((a % b != 0) && (a < 0)) r = r - 1;
    return r;
  endfunction

  function automatic res_t model(smp_t t);
    res_t   r;
    longint lim = longint'(1) << (D_BIT-1);
    longint m, q, sm, df;
    r.ovf = 0;
    if (t.byp) m = t.x1;
    else begin
      q = fdiv(t.x1*t.c + t.x2*t.s + (longint'(1) << (W_BIT-2)), longint'(1) << (W_BIT-1));
      if (q > lim-1)     begin m = lim-1; r.ovf = 1; end
      else if (q < -lim) begin m = -lim;  r.ovf = 1; end
      else m = q;
    end
    sm = t.x0 + m;
    df = t.x0 - m;
    if (t.scl) begin
      r.y0 = fdiv(sm+1, 2);
      r.y1 = fdiv(df+1, 2);
    end else begin
      r.y0 = sm; r.y1 = df;
      if (sm > lim-1) begin r.y0 = lim-1; r.ovf = 1; end
      if (sm < -lim)  begin r.y0 = -lim;  r.ovf = 1; end
      if (df > lim-1) begin r.y1 = lim-1; r.ovf = 1; end
      if (df < -lim)  begin r.y1 = -lim;  r.ovf = 1; end
    end
    return r;
  endfunction

  function automatic smp_t rand_smp(bit byp, bit scl);
    smp_t t;
    logic signed [D_BIT-1:0] d;
    logic signed [W_BIT-1:0] w;
    d = D_BIT'($urandom); t.x0 = longint'(d);
    d = D_BIT'($urandom); t.x1 = longint'(d);
    d = D_BIT'($urandom); t.x2 = longint'(d);
    w = W_BIT'($urandom); t.c  = longint'(w);
    w = W_BIT'($urandom); t.s  = longint'(w);
    t.byp = byp;
    t.scl = scl;
    return t;
  endfunction

  task automatic model_reset();
    m_stg_vld = 0; m_out_vld = 0; m_ovf = 0;
    m_stg = '{default: 0}; m_out = '{default: 0};
  endtask

  // drive one clock of stimulus, advance the reference model, sample 1ns after the edge
  task automatic cycle(input smp_t t, input bit vld, input bit stall, input bit clr);
    bus.iVALID   = vld;
    bus.iSTALL   = stall;
    bus.iOVF_CLR = clr;
    bus.iBYPASS  = t.byp;
    bus.iSCALE   = t.scl;
    bus.iX_0     = t.x0[D_BIT-1:0];
    bus.iX_1     = t.x1[D_BIT-1:0];
    bus.iX_2     = t.x2[D_BIT-1:0];
    bus.iCOS     = t.c[W_BIT-1:0];
    bus.iSIN     = t.s[W_BIT-1:0];
    if (stall) begin
      if (clr) m_ovf = 0;
    end else begin
      m_out_vld = m_stg_vld;
      m_out     = m_stg;
      m_stg_vld = vld;
      m_stg     = model(t);
      if (m_out_vld && m_out.ovf) m_ovf = 1;
      else if (clr)               m_ovf = 0;
    end
    @(posedge iCLK);
    #1;
  endtask

  task automatic test_reset();
    cycle(z, 0, 0, 0);
    iRESET = 1'b0;
    model_reset();
    #1;
    vectors++; if (bus.oVALID !== 1'b0) begin errors++; $display("FAIL reset oVALID got %b exp 0", bus.oVALID); end
    vectors++; if (bus.oY_0 !== '0) begin errors++; $display("FAIL reset oY_0 got %0d exp 0", bus.oY_0); end
    vectors++; if (bus.oY_1 !== '0) begin errors++; $display("FAIL reset oY_1 got %0d exp 0", bus.oY_1); end
    vectors++; if (bus.oOVF !== 1'b0) begin errors++; $display("FAIL reset oOVF got %b exp 0", bus.oOVF); end
    #3 iRESET = 1'b1;
    cycle(z, 0, 0, 0);
    cycle(z, 0, 0, 0);
    vectors++; if (bus.oVALID !== 1'b0) begin errors++; $display("FAIL reset_idle oVALID got %b exp 0", bus.oVALID); end
  endtask

  task automatic test_bypass_scale();
    smp_t t = '{x0: 100, x1: 50, x2: 0, c: 0, s: 0, byp: 1, scl: 1};
    cycle(t, 1, 0, 0);
    vectors++; if (bus.oVALID !== 1'b0) begin errors++; $display("FAIL byp_scale early oVALID got %b exp 0", bus.oVALID); end
    cycle(z, 0, 0, 0);
    vectors++; if (bus.oVALID !== 1'b1) begin errors++; $display("FAIL byp_scale oVALID got %b exp 1", bus.oVALID); end
    vectors++; if (longint'(bus.oY_0) !== 75) begin errors++; $display("FAIL byp_scale oY_0 got %0d exp 75", bus.oY_0); end
    vectors++; if (longint'(bus.oY_1) !== 25) begin errors++; $display("FAIL byp_scale oY_1 got %0d exp 25", bus.oY_1); end
    cycle(z, 0, 0, 0);
    vectors++; if (bus.oVALID !== 1'b0) begin errors++; $display("FAIL byp_scale pulse oVALID got %b exp 0", bus.oVALID); end
  endtask

  task automatic test_twiddle();
    smp_t t = '{x0: 0, x1: 1000, x2: 0, c: 1024, s: 0, byp: 0, scl: 0};
    cycle(t, 1, 0, 0);
    cycle(z, 0, 0, 0);
    vectors++; if (longint'(bus.oY_0) !== 500) begin errors++; $display("FAIL twiddle oY_0 got %0d exp 500", bus.oY_0); end
    vectors++; if (longint'(bus.oY_1) !== -500) begin errors++; $display("FAIL twiddle oY_1 got %0d exp -500", bus.oY_1); end
    vectors++; if (bus.oOVF !== 1'b0) begin errors++; $display("FAIL twiddle oOVF got %b exp 0", bus.oOVF); end
  endtask

  task automatic test_saturation();
    smp_t a = '{x0: 60000, x1: 10000, x2: 0, c: 0, s: 0, byp: 1, scl: 0};
    smp_t b = '{x0: 0, x1: -65536, x2: 0, c: -2048, s: 0, byp: 0, scl: 0};
    cycle(a, 1, 0, 0);
    cycle(z, 0, 0, 0);
    vectors++; if (longint'(bus.oY_0) !== 65535) begin errors++; $display("FAIL sat2 oY_0 got %0d exp 65535", bus.oY_0); end
    vectors++; if (longint'(bus.oY_1) !== 50000) begin errors++; $display("FAIL sat2 oY_1 got %0d exp 50000", bus.oY_1); end
    vectors++; if (bus.oOVF !== 1'b1) begin errors++; $display("FAIL sat2 oOVF got %b exp 1", bus.oOVF); end
    cycle(z, 0, 0, 0);
    vectors++; if (bus.oOVF !== 1'b1) begin errors++; $display("FAIL sat_hold oOVF got %b exp 1", bus.oOVF); end
    cycle(z, 0, 0, 1);
    vectors++; if (bus.oOVF !== 1'b0) begin errors++; $display("FAIL ovf_clr oOVF got %b exp 0", bus.oOVF); end
    cycle(b, 1, 0, 0);
    cycle(z, 0, 0, 0);
    vectors++; if (longint'(bus.oY_0) !== 65535) begin errors++; $display("FAIL sat1 oY_0 got %0d exp 65535", bus.oY_0); end
    vectors++; if (longint'(bus.oY_1) !== -65535) begin errors++; $display("FAIL sat1 oY_1 got %0d exp -65535", bus.oY_1); end
    vectors++; if (bus.oOVF !== 1'b1) begin errors++; $display("FAIL sat1 oOVF got %b exp 1", bus.oOVF); end
    cycle(z, 0, 1, 1);
    vectors++; if (bus.oOVF !== 1'b0) begin errors++; $display("FAIL stall_clr oOVF got %b exp 0", bus.oOVF); end
  endtask

  // 4 samples, stall for 3 cycles after the 2nd: 9 clocks total
  task automatic test_stall();
    int   n_out = 0;
    smp_t t;
    bit   vld, stl;
    for (int c = 0; c < 9; c++) begin
      vld = (c == 0) || (c == 1) || (c == 5) || (c == 6);
      stl = (c >= 2) && (c <= 4);
      t   = rand_smp(1'($urandom), 1'($urandom));
      cycle(t, vld, stl, 0);
      if (!stl && bus.oVALID) n_out++;
      vectors++;
      if (bus.oVALID !== m_out_vld) begin errors++; $display("FAIL stall c%0d oVALID got %b exp %b", c, bus.oVALID, m_out_vld); end
      else if (m_out_vld) begin
        vectors++;
        if (longint'(bus.oY_0) !== m_out.y0 || longint'(bus.oY_1) !== m_out.y1) begin
          errors++; $display("FAIL stall c%0d y got %0d/%0d exp %0d/%0d", c, bus.oY_0, bus.oY_1, m_out.y0, m_out.y1);
        end
      end
      vectors++; if (bus.oOVF !== m_ovf) begin errors++; $display("FAIL stall c%0d oOVF got %b exp %b", c, bus.oOVF, m_ovf); end
    end
    vectors++; if (n_out != 4) begin errors++; $display("FAIL stall count got %0d exp 4", n_out); end
    cycle(z, 0, 0, 1);
  endtask

  task automatic test_alternate();
    smp_t t;
    for (int c = 0; c < 10; c++) begin
      t = rand_smp(1'(c), 1'(c >> 1));
      cycle(t, c < 8, 0, 0);
      vectors++;
      if (bus.oVALID !== m_out_vld) begin errors++; $display("FAIL alt c%0d oVALID got %b exp %b", c, bus.oVALID, m_out_vld); end
      else if (m_out_vld) begin
        vectors++;
        if (longint'(bus.oY_0) !== m_out.y0 || longint'(bus.oY_1) !== m_out.y1) begin
          errors++; $display("FAIL alt c%0d y got %0d/%0d exp %0d/%0d", c, bus.oY_0, bus.oY_1, m_out.y0, m_out.y1);
        end
      end
      vectors++; if (bus.oOVF !== m_ovf) begin errors++; $display("FAIL alt c%0d oOVF got %b exp %b", c, bus.oOVF, m_ovf); end
    end
  endtask

  task automatic test_back_to_back();
    smp_t t;
    for (int c = 0; c < 60; c++) begin
      t = rand_smp(1'($urandom), 1'($urandom));
      cycle(t, $urandom_range(3) != 0, $urandom_range(3) == 0, $urandom_range(7) == 0);
      vectors++;
      if (bus.oVALID !== m_out_vld) begin errors++; $display("FAIL b2b c%0d oVALID got %b exp %b", c, bus.oVALID, m_out_vld); end
      else if (m_out_vld) begin
        vectors++;
        if (longint'(bus.oY_0) !== m_out.y0 || longint'(bus.oY_1) !== m_out.y1) begin
          errors++; $display("FAIL b2b c%0d y got %0d/%0d exp %0d/%0d", c, bus.oY_0, bus.oY_1, m_out.y0, m_out.y1);
        end
      end
      vectors++; if (bus.oOVF !== m_ovf) begin errors++; $display("FAIL b2b c%0d oOVF got %b exp %b", c, bus.oOVF, m_ovf); end
    end
  endtask

  task automatic test_reset_midflight();
    smp_t a = '{x0: 60000, x1: 10000, x2: 0, c: 0, s: 0, byp: 1, scl: 0};
    cycle(a, 1, 0, 0);
    cycle(rand_smp(0, 1), 1, 0, 0);
    cycle(rand_smp(1, 1), 1, 0, 0);
    #2 iRESET = 1'b0;
    model_reset();
    #1;
    vectors++; if (bus.oVALID !== 1'b0) begin errors++; $display("FAIL midrst oVALID got %b exp 0", bus.oVALID); end
    vectors++; if (bus.oY_0 !== '0 || bus.oY_1 !== '0) begin errors++; $display("FAIL midrst y got %0d/%0d exp 0/0", bus.oY_0, bus.oY_1); end
    vectors++; if (bus.oOVF !== 1'b0) begin errors++; $display("FAIL midrst oOVF got %b exp 0", bus.oOVF); end
    #2 iRESET = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle(z, 0, 0, 0);
      vectors++; if (bus.oVALID !== 1'b0) begin errors++; $display("FAIL midrst_rel c%0d oVALID got %b exp 0", c, bus.oVALID); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_bypass_scale();
    test_twiddle();
    test_saturation();
    test_stall();
    test_alternate();
    test_back_to_back();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
